// File: rtl/jtbubl_sdram_mux.sv
// rtl/jtbubl_sdram_mux.sv - N-slot cached ROM request arbiter for the single SDRAM read port
module jtbubl_sdram_mux #(
    parameter int                  SLOTS     = 5,
    parameter int                  SAW       = 18,
    parameter logic [SLOTS*22-1:0] OFFSET    = '0,
    parameter bit                  RR        = 1'b0,
    parameter logic [SLOTS-1:0]    BOOT_MASK = SLOTS'(5'h0f)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 downloading,
    input  logic [SLOTS-1:0]     slot_cs,
    input  logic [SLOTS*SAW-1:0] slot_addr,
    output logic [SLOTS-1:0]     slot_ok,
    output logic [SLOTS*32-1:0]  slot_dout,
    output logic                 sdram_req,
    output logic [21:0]          sdram_addr,
    input  logic                 sdram_ack,
    input  logic                 data_dst,
    input  logic                 data_rdy,
    input  logic [31:0]          data_read,
    output logic                 cpu_start
);
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t           state;
    logic [IW-1:0]    gnt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gsel;
    logic [IW-1:0]    gnext;
    logic [SLOTS-1:0] valid;
    logic [SLOTS-1:0] eff_cs;
    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] pending;
    logic [SAW-1:0]   tag    [SLOTS];
    logic [SAW-1:0]   addr_a [SLOTS];
    logic [21:0]      off_a  [SLOTS];
    logic [31:0]      dout   [SLOTS];
    logic [21:0]      gsdram;
    logic             unused_dst;

    // Burst start is not needed: data_rdy alone qualifies the read word.
    assign unused_dst = data_dst;

    // Boot slots keep requesting until the CPUs are released.
    assign eff_cs  = slot_cs | (BOOT_MASK & {SLOTS{~cpu_start}});
    assign slot_ok = eff_cs & hit;
    assign pending = eff_cs & ~hit;

    // Unpack per-slot address/offset/data and compare each address with its cached tag.
    always_comb begin
        hit       = '0;
        slot_dout = '0;
        for (int i = 0; i < SLOTS; i++) begin
            addr_a[i] = slot_addr[i*SAW +: SAW];
            off_a[i]  = OFFSET[i*22 +: 22];
            hit[i]    = valid[i] && (tag[i] == addr_a[i]);
            slot_dout[i*32 +: 32] = dout[i];
        end
    end

    // Pick the winning slot: lowest index, or first at/after ptr with wrap in round-robin mode.
    always_comb begin
        logic [IW-1:0] idx;
        gsel = '0;
        idx  = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            idx = RR ? IW'((int'(ptr) + k) % SLOTS) : IW'(k);
            if (pending[idx]) gsel = idx;
        end
        gnext  = (int'(gsel) == SLOTS - 1) ? '0 : gsel + 1'b1;
        gsdram = 22'(addr_a[gsel]) + off_a[gsel];
    end

    // Request FSM, cache fill and boot gate; downloading aborts everything and re-arms the boot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            ptr        <= '0;
            valid      <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            cpu_start  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                tag[i]  <= '0;
                dout[i] <= '0;
            end
        end else if (downloading) begin
            state     <= IDLE;
            valid     <= '0;
            sdram_req <= 1'b0;
            cpu_start <= 1'b0;
        end else begin
            if (&(slot_ok | ~BOOT_MASK)) cpu_start <= 1'b1;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        gnt         <= gsel;
                        tag[gsel]   <= addr_a[gsel];
                        valid[gsel] <= 1'b0;
                        sdram_addr  <= gsdram;
                        sdram_req   <= 1'b1;
                        state       <= WAIT_ACK;
                        if (RR) ptr <= gnext;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (data_rdy) begin
                        dout[gnt]  <= data_read;
                        valid[gnt] <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtbubl_sdram_mux.sv
// tb/tb_jtbubl_sdram_mux.sv - randomized self-checking bench for jtbubl_sdram_mux
`timescale 1ns/1ps
module tb_jtbubl_sdram_mux;
    localparam int SLOTS = 5;
    localparam int SAW   = 18;
    localparam logic [SLOTS*22-1:0] OFFS = {22'h3ff000, 22'h014000, 22'h002000, 22'h001000, 22'h000000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dl  = 1'b0;
    always #5 clk = ~clk;

    logic [SLOTS-1:0]     cs0 = '0;
    logic [SLOTS-1:0]     cs1 = '0;
    logic [SAW-1:0]       a0 [SLOTS];
    logic [SAW-1:0]       a1 [SLOTS];
    logic [SLOTS*SAW-1:0] pa0, pa1;
    logic [SLOTS-1:0]     ok0, ok1;
    logic [SLOTS*32-1:0]  dout0, dout1;
    logic [1:0]           req_v, start_v;
    logic [21:0]          addr_v [2];
    logic                 ack_v  [2] = '{1'b0, 1'b0};
    logic                 rdy_v  [2] = '{1'b0, 1'b0};
    logic [31:0]          rd_v   [2] = '{32'h0, 32'h0};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rdy0 = -1;
    logic [21:0] gq0[$];
    logic [21:0] gq1[$];
    logic [1:0]  req_prev = 2'b00;

    always_comb begin
        pa0 = '0;
        pa1 = '0;
        for (int i = 0; i < SLOTS; i++) begin
            pa0[i*SAW +: SAW] = a0[i];
            pa1[i*SAW +: SAW] = a1[i];
        end
    end

    jtbubl_sdram_mux #(.SLOTS(SLOTS), .SAW(SAW), .OFFSET(OFFS), .RR(1'b0), .BOOT_MASK(5'h0f)) dut (
        .clk(clk), .rst(rst), .downloading(dl), .slot_cs(cs0), .slot_addr(pa0),
        .slot_ok(ok0), .slot_dout(dout0), .sdram_req(req_v[0]), .sdram_addr(addr_v[0]),
        .sdram_ack(ack_v[0]), .data_dst(1'b0), .data_rdy(rdy_v[0]), .data_read(rd_v[0]),
        .cpu_start(start_v[0])
    );

    jtbubl_sdram_mux #(.SLOTS(SLOTS), .SAW(SAW), .OFFSET(OFFS), .RR(1'b1), .BOOT_MASK(5'h00)) dut_rr (
        .clk(clk), .rst(rst), .downloading(1'b0), .slot_cs(cs1), .slot_addr(pa1),
        .slot_ok(ok1), .slot_dout(dout1), .sdram_req(req_v[1]), .sdram_addr(addr_v[1]),
        .sdram_ack(ack_v[1]), .data_dst(1'b0), .data_rdy(rdy_v[1]), .data_read(rd_v[1]),
        .cpu_start(start_v[1])
    );

    function automatic logic [31:0] mem(input logic [21:0] a);
        return {a[9:0], a} ^ 32'ha5c3_0f1e;
    endfunction

    function automatic logic [21:0] wrap(input logic [SAW-1:0] a, input int i);
        logic [21:0] off;
        off = OFFS[i*22 +: 22];
        return 22'(a) + off;
    endfunction

    function automatic logic [31:0] word(input logic [SLOTS*32-1:0] d, input int i);
        return d[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // SDRAM: ack two cycles after the request, data two cycles after the ack.
    task automatic sdram_model(input int k);
        logic [21:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (req_v[k]) begin
                a = addr_v[k];
                @(posedge clk); #1 ack_v[k] = 1'b1;
                @(posedge clk); #1 ack_v[k] = 1'b0;
                @(posedge clk); #1 rdy_v[k] = 1'b1; rd_v[k] = mem(a);
                @(posedge clk); #1 rdy_v[k] = 1'b0;
            end
        end
    endtask

    initial begin
        fork
            sdram_model(0);
            sdram_model(1);
        join_none
    end

    // Grant log: every rising sdram_req records the requested address.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rdy_v[0] && !rst) last_rdy0 = cyc;
        #1;
        if (req_v[0] && !req_prev[0]) gq0.push_back(addr_v[0]);
        if (req_v[1] && !req_prev[1]) gq1.push_back(addr_v[1]);
        req_prev = req_v;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cycles=%0d required=finish", cyc);
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < SLOTS; i++) begin
            a0[i] = 18'($urandom_range(32'h200, 32'hfff));
            a1[i] = '0;
        end
        repeat (3) tick();
        checks++; if (ok0 !== '0) begin failures++; $display("FAIL reset_ok got=%h want=0", ok0); end
        checks++; if (req_v[0] !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", req_v[0]); end
        checks++; if (addr_v[0] !== 22'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", addr_v[0]); end
        checks++; if (dout0 !== '0) begin failures++; $display("FAIL reset_dout got=%h want=0", dout0); end
        checks++; if (start_v !== 2'b00) begin failures++; $display("FAIL reset_start got=%b want=00", start_v); end
        rst = 1'b0;
        tick();
        checks++; if (start_v[1] !== 1'b1) begin failures++; $display("FAIL rr_start_no_boot got=%b want=1", start_v[1]); end
    endtask

    task automatic test_boot();
        int t;
        int rise;
        t = 0;
        while (start_v[0] !== 1'b1 && t < 200) begin tick(); t++; end
        rise = cyc;
        checks++; if (start_v[0] !== 1'b1) begin failures++; $display("FAIL boot_timeout start=%b want=1", start_v[0]); end
        checks++; if (rise != last_rdy0 + 1) begin failures++; $display("FAIL boot_start_cycle got=%0d want=%0d", rise, last_rdy0 + 1); end
        checks++; if (gq0.size() != 4) begin failures++; $display("FAIL boot_grant_count got=%0d want=4", gq0.size()); end
        for (int i = 0; i < 4; i++) begin
            if (gq0.size() > i) begin
                checks++;
                if (gq0[i] !== wrap(a0[i], i)) begin failures++; $display("FAIL boot_grant%0d got=%h want=%h", i, gq0[i], wrap(a0[i], i)); end
            end
            checks++;
            if (word(dout0, i) !== mem(wrap(a0[i], i))) begin failures++; $display("FAIL boot_dout%0d got=%h want=%h", i, word(dout0, i), mem(wrap(a0[i], i))); end
        end
        checks++; if (ok0 !== '0) begin failures++; $display("FAIL boot_ok_after_release got=%h want=0", ok0); end
        cs0 = 5'h0f;
        #1;
        checks++; if (ok0 !== 5'h0f) begin failures++; $display("FAIL boot_cached_hit got=%h want=0f", ok0); end
        repeat (4) tick();
        checks++; if (gq0.size() != 4) begin failures++; $display("FAIL boot_no_refetch got=%0d want=4", gq0.size()); end
    endtask

    task automatic test_priority();
        int n;
        int t;
        cs0 = '0;
        tick();
        a0[1] = 18'h02345;
        a0[3] = 18'h00123;
        n = gq0.size();
        cs0 = 5'b01010;
        t = 0;
        while (ok0 !== 5'b01010 && t < 100) begin tick(); t++; end
        checks++; if (ok0 !== 5'b01010) begin failures++; $display("FAIL prio_ok got=%h want=0a", ok0); end
        checks++; if (gq0.size() != n + 2) begin failures++; $display("FAIL prio_count got=%0d want=%0d", gq0.size(), n + 2); end
        else begin
            checks++; if (gq0[n] !== 22'h003345) begin failures++; $display("FAIL prio_first got=%h want=003345", gq0[n]); end
            checks++; if (gq0[n+1] !== 22'h014123) begin failures++; $display("FAIL prio_second got=%h want=014123", gq0[n+1]); end
        end
        checks++; if (word(dout0, 3) !== mem(22'h014123)) begin failures++; $display("FAIL prio_dout3 got=%h want=%h", word(dout0, 3), mem(22'h014123)); end
    endtask

    task automatic test_rr();
        int n;
        int t;
        int p;
        int s;
        n = gq1.size();
        for (int i = 0; i < 3; i++) a1[i] = 18'(i * 16);
        cs1 = 5'b00111;
        t = 0;
        while (gq1.size() < n + 6 && t < 300) begin
            tick();
            for (int i = 0; i < 3; i++) if (ok1[i]) a1[i] = a1[i] + 1'b1;
            t++;
        end
        checks++; if (gq1.size() < n + 6) begin failures++; $display("FAIL rr_count got=%0d want=%0d", gq1.size() - n, 6); end
        else begin
            p = 0;
            for (int j = 0; j < 6; j++) begin
                s = -1;
                for (int k = 0; k < SLOTS && s < 0; k++) if ((p + k) % SLOTS < 3) s = (p + k) % SLOTS;
                checks++;
                if (int'(gq1[n+j] >> 12) != s) begin failures++; $display("FAIL rr_order%0d got=%0d want=%0d", j, gq1[n+j] >> 12, s); end
                p = (s + 1) % SLOTS;
            end
        end
        cs1 = '0;
    endtask

    task automatic test_addr_change();
        int n;
        int t;
        cs0 = '0;
        tick();
        a0[0] = 18'h10;
        cs0 = 5'h01;
        t = 0;
        while (ok0[0] !== 1'b1 && t < 100) begin tick(); t++; end
        checks++; if (word(dout0, 0) !== mem(22'h10) || ok0[0] !== 1'b1) begin failures++; $display("FAIL chg_first ok=%b dout=%h want=1 %h", ok0[0], word(dout0, 0), mem(22'h10)); end
        tick();
        n = gq0.size();
        a0[0] = 18'h11;
        #1;
        checks++; if (ok0[0] !== 1'b0) begin failures++; $display("FAIL chg_ok_fall got=%b want=0", ok0[0]); end
        t = 0;
        while (ok0[0] !== 1'b1 && t < 100) begin tick(); t++; end
        checks++; if (gq0.size() != n + 1 || gq0[gq0.size()-1] !== 22'h11) begin failures++; $display("FAIL chg_refetch count=%0d want=%0d", gq0.size(), n + 1); end
        checks++; if (word(dout0, 0) !== mem(22'h11)) begin failures++; $display("FAIL chg_dout got=%h want=%h", word(dout0, 0), mem(22'h11)); end
        cs0 = '0;
        repeat (3) tick();
        cs0 = 5'h01;
        #1;
        checks++; if (ok0[0] !== 1'b1) begin failures++; $display("FAIL chg_rehit got=%b want=1", ok0[0]); end
        repeat (5) tick();
        checks++; if (gq0.size() != n + 1) begin failures++; $display("FAIL chg_no_request got=%0d want=%0d", gq0.size(), n + 1); end
    endtask

    task automatic test_download();
        int n;
        int t;
        logic [21:0] exp[$];
        cs0 = '0;
        tick();
        a0[4] = 18'h31000;
        n = gq0.size();
        cs0 = 5'h10;
        t = 0;
        while (req_v[0] !== 1'b1 && t < 50) begin tick(); t++; end
        t = 0;
        while (req_v[0] !== 1'b0 && t < 50) begin tick(); t++; end
        checks++; if (gq0.size() != n + 1 || gq0[gq0.size()-1] !== 22'h030000) begin failures++; $display("FAIL dl_wrap_addr count=%0d want=%0d", gq0.size(), n + 1); end
        dl = 1'b1;
        tick();
        checks++; if (req_v[0] !== 1'b0 || ok0 !== '0 || start_v[0] !== 1'b0) begin failures++; $display("FAIL dl_abort req=%b ok=%h start=%b want=0 00 0", req_v[0], ok0, start_v[0]); end
        dl = 1'b0;
        tick();
        checks++; if (ok0[4] !== 1'b0 || word(dout0, 4) !== 32'h0) begin failures++; $display("FAIL dl_late_data ok4=%b dout4=%h want=0 0", ok0[4], word(dout0, 4)); end
        for (int i = 0; i < 4; i++) exp.push_back(wrap(a0[i], i));
        exp.push_back(22'h030000);
        t = 0;
        while (!(start_v[0] === 1'b1 && ok0[4] === 1'b1) && t < 300) begin tick(); t++; end
        checks++; if (start_v[0] !== 1'b1 || ok0[4] !== 1'b1) begin failures++; $display("FAIL dl_reboot start=%b ok4=%b want=1 1", start_v[0], ok0[4]); end
        checks++; if (gq0.size() != n + 6) begin failures++; $display("FAIL dl_grant_count got=%0d want=%0d", gq0.size() - n, 6); end
        else for (int j = 0; j < 5; j++) begin
            checks++;
            if (gq0[n+1+j] !== exp[j]) begin failures++; $display("FAIL dl_grant%0d got=%h want=%h", j, gq0[n+1+j], exp[j]); end
        end
        checks++; if (word(dout0, 4) !== mem(22'h030000)) begin failures++; $display("FAIL dl_dout4 got=%h want=%h", word(dout0, 4), mem(22'h030000)); end
    endtask

    task automatic test_tag();
        int n;
        int t;
        cs0 = '0;
        tick();
        a0[2] = 18'h03000;
        n = gq0.size();
        cs0 = 5'h04;
        t = 0;
        while (req_v[0] !== 1'b1 && t < 50) begin tick(); t++; end
        t = 0;
        while (req_v[0] !== 1'b0 && t < 50) begin tick(); t++; end
        a0[2] = 18'h03001;
        t = 0;
        while (last_rdy0 != cyc && t < 50) begin tick(); t++; end
        checks++; if (ok0[2] !== 1'b0) begin failures++; $display("FAIL tag_ok_stays_low got=%b want=0", ok0[2]); end
        checks++; if (word(dout0, 2) !== mem(22'h005000)) begin failures++; $display("FAIL tag_old_word got=%h want=%h", word(dout0, 2), mem(22'h005000)); end
        t = 0;
        while (ok0[2] !== 1'b1 && t < 100) begin tick(); t++; end
        checks++; if (gq0.size() != n + 2 || gq0[n] !== 22'h005000 || gq0[n+1] !== 22'h005001) begin failures++; $display("FAIL tag_refetch count=%0d want=%0d", gq0.size() - n, 2); end
        checks++; if (word(dout0, 2) !== mem(22'h005001)) begin failures++; $display("FAIL tag_new_word got=%h want=%h", word(dout0, 2), mem(22'h005001)); end
    endtask

    task automatic test_random();
        logic [SAW-1:0]   tagm [SLOTS];
        bit               valm [SLOTS];
        logic [SLOTS-1:0] cs;
        logic [21:0]      exp[$];
        int n;
        int t;
        bit bad;
        for (int i = 0; i < SLOTS; i++) valm[i] = 1'b0;
        cs0 = '0;
        tick();
        for (int it = 0; it < 24; it++) begin
            cs = SLOTS'($urandom_range(1, 31));
            for (int i = 0; i < SLOTS; i++) a0[i] = 18'h2a000 + 18'($urandom_range(0, 3));
            exp.delete();
            for (int i = 0; i < SLOTS; i++)
                if (cs[i] && !(valm[i] && tagm[i] == a0[i])) exp.push_back(wrap(a0[i], i));
            n = gq0.size();
            cs0 = cs;
            t = 0;
            while (ok0 !== cs && t < 300) begin tick(); t++; end
            checks++; if (ok0 !== cs) begin failures++; $display("FAIL rand%0d_ok got=%h want=%h", it, ok0, cs); end
            bad = (gq0.size() != n + exp.size());
            if (!bad) for (int j = 0; j < exp.size(); j++) if (gq0[n+j] !== exp[j]) bad = 1'b1;
            checks++; if (bad) begin failures++; $display("FAIL rand%0d_grants got=%0d want=%0d", it, gq0.size() - n, exp.size()); end
            bad = 1'b0;
            for (int i = 0; i < SLOTS; i++) if (cs[i] && word(dout0, i) !== mem(wrap(a0[i], i))) bad = 1'b1;
            checks++; if (bad) begin failures++; $display("FAIL rand%0d_dout got=%h cs=%h", it, dout0, cs); end
            for (int i = 0; i < SLOTS; i++) if (cs[i]) begin valm[i] = 1'b1; tagm[i] = a0[i]; end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_priority();
        test_rr();
        test_addr_change();
        test_download();
        test_tag();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
